// File: rtl/cfg_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StShift,
        StDrain
    } state_e;

    // Chain length of the target cipher: four M-bit LFSR fields plus two control bits.
    function automatic int unsigned chain_len(input int unsigned m);
        return 4 * m + 2;
    endfunction

    // Host words needed to carry one full chain image.
    function automatic int unsigned num_words(input int unsigned m, input int unsigned w);
        return (chain_len(m) + w - 1) / w;
    endfunction

endpackage

// File: rtl/cfg_shift_buf.sv
// Image buffer (word-parallel load, serial out LSB first) and readback buffer
// (serial in, word-parallel read) for one configuration frame.
module cfg_shift_buf
    import cfg_loader_pkg::*;
#(
    parameter int unsigned M = 32,
    parameter int unsigned W = 8,
    localparam int unsigned L = chain_len(M),
    localparam int unsigned NW = num_words(M, W),
    localparam int unsigned WCW = $clog2(NW + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_wr_en,
    input  logic [WCW-1:0] i_wr_idx,
    input  logic [W-1:0]   i_wr_data,
    input  logic           i_img_shift,
    input  logic           i_rb_shift,
    input  logic           i_cfg_o,
    input  logic [WCW-1:0] i_rd_idx,
    output logic           o_img_bit,
    output logic [W-1:0]   o_rb_word
);

    localparam int unsigned PW = $clog2(L);

    logic [L-1:0] r_img;
    logic [L-1:0] r_rb;
    logic [L-1:0] w_img_d;
    logic [L-1:0] w_rb_nxt;

    // Word write first, then shift: the final word lands on the same edge as the
    // first shift, so its bits must move down together with the rest of the image.
    always_comb begin
        int p;
        p = 0;
        w_img_d = r_img;
        if (i_wr_en) begin
            for (int b = 0; b < int'(W); b++) begin
                p = int'(i_wr_idx) * int'(W) + b;
                if (p < int'(L)) begin
                    w_img_d[PW'(p)] = i_wr_data[b];
                end
            end
        end
        if (i_img_shift) begin
            w_img_d = {1'b0, w_img_d[L-1:1]};
        end
    end

    // Readback fills from the top so the first captured bit ends up at index 0.
    always_comb begin
        w_rb_nxt = i_rb_shift ? {i_cfg_o, r_rb[L-1:1]} : r_rb;
    end

    // Read port sees the post-capture value so word 0 is valid on the final shift edge.
    always_comb begin
        int p;
        p = 0;
        o_rb_word = '0;
        for (int b = 0; b < int'(W); b++) begin
            p = int'(i_rd_idx) * int'(W) + b;
            o_rb_word[b] = (p < int'(L)) ? w_rb_nxt[PW'(p)] : 1'b0;
        end
    end

    assign o_img_bit = r_img[0];

    // Buffer registers; reset discards any partial image or readback.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_img <= '0;
            r_rb  <= '0;
        end else begin
            r_img <= w_img_d;
            r_rb  <= w_rb_nxt;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Host-side writer for the cipher configuration chain: collects an image over a
// valid/ready port, shifts it in as one unbroken cfg_en burst, and returns the
// displaced previous image. Assumes the image spans at least two host words.
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned M = 32,
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_in_data,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [W-1:0] o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_cfg_en,
    output logic         o_cfg_i,
    input  logic         i_cfg_o,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned L = chain_len(M);
    localparam int unsigned NW = num_words(M, W);
    localparam int unsigned BW = $clog2(L + 1);
    localparam int unsigned WCW = $clog2(NW + 1);

    localparam logic [BW-1:0]  LastBit = BW'(L - 1);
    // FILL counts words after the one accepted in IDLE.
    localparam logic [WCW-1:0] LastFillCnt = WCW'(NW - 2);
    localparam logic [WCW-1:0] LastWord = WCW'(NW - 1);

    state_e         r_state;
    logic [BW-1:0]  r_bit_cnt;
    logic [WCW-1:0] r_word_cnt;
    logic           r_cfg_en;
    logic           r_cfg_i;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_busy;
    logic           r_done;

    state_e         w_state_d;
    logic [BW-1:0]  w_bit_cnt_d;
    logic [WCW-1:0] w_word_cnt_d;
    logic           w_cfg_en_d;
    logic           w_cfg_i_d;
    logic           w_in_ready_d;
    logic           w_out_valid_d;
    logic [W-1:0]   w_out_data_d;
    logic           w_busy_d;
    logic           w_done_d;

    logic           w_in_hs;
    logic           w_out_hs;
    logic           w_wr_en;
    logic [WCW-1:0] w_wr_idx;
    logic           w_img_shift;
    logic           w_rb_shift;
    logic [WCW-1:0] w_rd_idx;
    logic           w_img_bit;
    logic [W-1:0]   w_rb_word;

    assign w_in_hs  = i_in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & i_out_ready;

    cfg_shift_buf #(
        .M (M),
        .W (W)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_wr_idx),
        .i_wr_data   (i_in_data),
        .i_img_shift (w_img_shift),
        .i_rb_shift  (w_rb_shift),
        .i_cfg_o     (i_cfg_o),
        .i_rd_idx    (w_rd_idx),
        .o_img_bit   (w_img_bit),
        .o_rb_word   (w_rb_word)
    );

    // Next state, counters and next values of the registered outputs.
    always_comb begin
        w_state_d     = r_state;
        w_bit_cnt_d   = r_bit_cnt;
        w_word_cnt_d  = r_word_cnt;
        w_cfg_en_d    = 1'b0;
        w_cfg_i_d     = 1'b0;
        w_in_ready_d  = 1'b0;
        w_out_valid_d = 1'b0;
        w_out_data_d  = r_out_data;
        w_busy_d      = r_busy;
        w_done_d      = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_idx      = '0;
        w_img_shift   = 1'b0;
        w_rb_shift    = 1'b0;
        w_rd_idx      = '0;

        unique case (r_state)
            StIdle: begin
                w_in_ready_d = 1'b1;
                w_out_data_d = '0;
                if (w_in_hs) begin
                    w_wr_en      = 1'b1;
                    w_wr_idx     = '0;
                    w_state_d    = StFill;
                    w_bit_cnt_d  = '0;
                    w_word_cnt_d = '0;
                    w_busy_d     = 1'b1;
                end
            end
            StFill: begin
                w_in_ready_d = 1'b1;
                if (w_in_hs) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_word_cnt + 1'b1;
                    if (r_word_cnt == LastFillCnt) begin
                        // First burst cycle follows this edge directly.
                        w_state_d    = StShift;
                        w_bit_cnt_d  = '0;
                        w_word_cnt_d = '0;
                        w_in_ready_d = 1'b0;
                        w_cfg_en_d   = 1'b1;
                        w_cfg_i_d    = w_img_bit;
                        w_img_shift  = 1'b1;
                    end else begin
                        w_word_cnt_d = r_word_cnt + 1'b1;
                    end
                end
            end
            StShift: begin
                w_rb_shift  = 1'b1;
                w_img_shift = 1'b1;
                if (r_bit_cnt == LastBit) begin
                    w_state_d     = StDrain;
                    w_bit_cnt_d   = '0;
                    w_word_cnt_d  = '0;
                    w_out_valid_d = 1'b1;
                    w_rd_idx      = '0;
                    w_out_data_d  = w_rb_word;
                end else begin
                    w_bit_cnt_d = r_bit_cnt + 1'b1;
                    w_cfg_en_d  = 1'b1;
                    w_cfg_i_d   = w_img_bit;
                end
            end
            StDrain: begin
                w_out_valid_d = 1'b1;
                if (w_out_hs) begin
                    if (r_word_cnt == LastWord) begin
                        w_state_d     = StIdle;
                        w_bit_cnt_d   = '0;
                        w_word_cnt_d  = '0;
                        w_out_valid_d = 1'b0;
                        w_out_data_d  = '0;
                        w_done_d      = 1'b1;
                        w_busy_d      = 1'b0;
                    end else begin
                        w_word_cnt_d = r_word_cnt + 1'b1;
                        w_rd_idx     = r_word_cnt + 1'b1;
                        w_out_data_d = w_rb_word;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_cfg_en    <= 1'b0;
            r_cfg_i     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_word_cnt  <= w_word_cnt_d;
            r_cfg_en    <= w_cfg_en_d;
            r_cfg_i     <= w_cfg_i_d;
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
            r_out_data  <= w_out_data_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_cfg_en    = r_cfg_en;
    assign o_cfg_i     = r_cfg_i;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: cipher chain model, frame table, reset corner cases.
module tb_cfg_chain_loader;

    localparam int M  = 32;
    localparam int W  = 8;
    localparam int L  = 130;
    localparam int NW = 17;

    // Cipher reset image: a_mux, d_en, two tap words, two state words.
    localparam logic [L-1:0] ResetChain =
        {32'h0000_0055, 32'h0000_0055, 32'h4800_0000, 32'h4800_0000, 1'b0, 1'b0};

    typedef struct {
        logic [135:0] img;
        logic [135:0] exp_rb;
        int           gap_w;
        int           gap_n;
        int           stall_w;
        int           stall_n;
        bit           preload;
    } frame_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         cfg_en;
    logic         cfg_i;
    logic         cfg_o;
    logic         busy;
    logic         done;

    logic [L-1:0] chain;
    logic         preload_req;

    int  n_checks;
    int  n_fail;
    int  tmo;
    bit  gap_bad;
    bit  stall_bad;

    int  runs;
    int  en_cnt;
    int  done_cnt;
    time first_en_t;
    time last_en_t;
    time first_ov_t;
    logic prev_en;
    logic prev_ov;
    logic seq_all [0:4095];

    frame_t tbl [5];

    cfg_chain_loader #(
        .M (M),
        .W (W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_cfg_en    (cfg_en),
        .o_cfg_i     (cfg_i),
        .i_cfg_o     (cfg_o),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher chain: shifts toward bit 0 on every cfg_en edge, cfg_o is the old bit 0.
    always @(posedge clk) begin
        if (preload_req) chain <= ResetChain;
        else if (cfg_en) chain <= {cfg_i, chain[L-1:1]};
    end
    assign cfg_o = chain[0];

    // Burst / done / out_valid monitor, sampled mid-cycle.
    initial begin
        runs = 0; en_cnt = 0; done_cnt = 0;
        first_en_t = 0; last_en_t = 0; first_ov_t = 0;
        prev_en = 1'b0; prev_ov = 1'b0;
    end
    always @(negedge clk) begin
        if (cfg_en === 1'b1) begin
            if (prev_en !== 1'b1) begin
                runs       <= runs + 1;
                first_en_t <= $time;
            end
            if (en_cnt < 4096) seq_all[en_cnt] <= cfg_i;
            en_cnt    <= en_cnt + 1;
            last_en_t <= $time;
        end
        if (out_valid === 1'b1 && prev_ov !== 1'b1) first_ov_t <= $time;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        prev_en <= cfg_en;
        prev_ov <= out_valid;
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one image; returns at the negedge of the first burst cycle.
    task automatic fill_frame(input logic [135:0] img, input int gap_w, input int gap_n,
                              output time hs_t);
        int g;
        gap_bad = 1'b0;
        hs_t = 0;
        for (int j = 0; j < NW; j++) begin
            in_valid = 1'b1;
            in_data  = img[j*W +: W];
            g = 0;
            while (in_ready !== 1'b1 && g < 400) begin
                @(negedge clk);
                g++;
            end
            if (g >= 400) begin
                tmo++;
                in_valid = 1'b0;
                return;
            end
            hs_t = $time + 5;
            @(negedge clk);
            if (j == gap_w && gap_n > 0) begin
                in_valid = 1'b0;
                repeat (gap_n) begin
                    if (cfg_en !== 1'b0 || busy !== 1'b1) gap_bad = 1'b1;
                    @(negedge clk);
                end
            end
        end
    endtask

    // Collects all readback words; returns at the negedge of the done cycle.
    task automatic drain_frame(input int stall_w, input int stall_n, output logic [135:0] rb);
        int g;
        logic [W-1:0] d0;
        rb = '0;
        stall_bad = 1'b0;
        for (int j = 0; j < NW; j++) begin
            g = 0;
            while (out_valid !== 1'b1 && g < 400) begin
                @(negedge clk);
                g++;
            end
            if (g >= 400) begin
                tmo++;
                return;
            end
            if (j == stall_w && stall_n > 0) begin
                out_ready = 1'b0;
                d0 = out_data;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (out_data !== d0 || out_valid !== 1'b1) stall_bad = 1'b1;
                end
                out_ready = 1'b1;
            end
            rb[j*W +: W] = out_data;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int idx);
        frame_t       f;
        logic [135:0] rb;
        logic [L-1:0] seq;
        int           runs0;
        int           en0;
        int           done0;
        time          hs_t;
        f = tbl[idx];
        if (f.preload) begin
            preload_req = 1'b1;
            @(negedge clk);
            preload_req = 1'b0;
        end
        tmo   = 0;
        runs0 = runs;
        en0   = en_cnt;
        done0 = done_cnt;
        fill_frame(f.img, f.gap_w, f.gap_n, hs_t);
        // Junk on the input port while shifting/draining must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        drain_frame(f.stall_w, f.stall_n, rb);
        check($sformatf("f%0d_done_cycle", idx), {done, busy}, 2'b10);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < L; i++) seq[i] = seq_all[en0 + i];
        check($sformatf("f%0d_timeout", idx), tmo, 0);
        check($sformatf("f%0d_bursts", idx), runs - runs0, 1);
        check($sformatf("f%0d_burst_len", idx), en_cnt - en0, L);
        check($sformatf("f%0d_cfg_i_seq", idx), seq, f.img[L-1:0]);
        check($sformatf("f%0d_en_latency", idx), first_en_t, hs_t + 5);
        check($sformatf("f%0d_ov_latency", idx), first_ov_t, last_en_t + 10);
        check($sformatf("f%0d_readback", idx), rb, f.exp_rb);
        check($sformatf("f%0d_done_count", idx), done_cnt - done0, 1);
        check($sformatf("f%0d_chain", idx), chain, f.img[L-1:0]);
        if (f.gap_n > 0) check($sformatf("f%0d_gap_quiet", idx), gap_bad, 1'b0);
        if (f.stall_n > 0) check($sformatf("f%0d_stall_stable", idx), stall_bad, 1'b0);
    endtask

    initial begin
        time hs_t;
        int  runs0;
        int  en0;
        int  done0;

        n_checks = 0;
        n_fail   = 0;
        tmo      = 0;

        tbl[0] = '{136'h10_0F0E0D0C0B0A0908_0706050403020100, {6'b0, ResetChain},
                   -1, 0, -1, 0, 1'b1};
        tbl[1] = '{{17{8'hA5}}, 136'h00_0F0E0D0C0B0A0908_0706050403020100,
                   -1, 0, -1, 0, 1'b0};
        tbl[2] = '{{17{8'h5A}}, {8'h01, {16{8'hA5}}}, 7, 5, -1, 0, 1'b0};
        tbl[3] = '{{17{8'h3C}}, {8'h02, {16{8'h5A}}}, -1, 0, 3, 4, 1'b0};
        tbl[4] = '{{17{8'h69}}, {6'b0, ResetChain}, -1, 0, -1, 0, 1'b1};

        // Reset held with in_valid asserted: nothing may be accepted.
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'hFF;
        out_ready   = 1'b1;
        preload_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  {cfg_en, cfg_i, in_ready, out_valid, busy, done, out_data}, '0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("reset_no_accept", {busy, cfg_en, out_valid}, 3'b000);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(i);

        // Reset in the middle of the burst.
        tmo   = 0;
        runs0 = runs;
        en0   = en_cnt;
        done0 = done_cnt;
        fill_frame({17{8'hC3}}, -1, 0, hs_t);
        in_valid = 1'b0;
        repeat (60) @(negedge clk);
        check("mr_en_before", cfg_en, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_outputs_dropped", {cfg_en, busy, done, in_ready, out_valid}, 5'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_timeout", tmo, 0);
        check("mr_no_done", done_cnt - done0, 0);
        check("mr_partial_burst", en_cnt - en0, 61);
        check("mr_one_burst", runs - runs0, 1);

        run_frame(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
